// File: rtl/sobel_window_gen_if.sv
// sobel_window_gen_if: handshake/bus bundle for the 3x3 window generator.
//   start/busy/done       frame control
//   pix_in/in_valid/in_ready   raster-order pixel input stream
//   win_out/win_row/win_col/win_last/win_valid/win_ready   window output stream
// Modport slave is the generator's view; master is the surrounding logic's view.
interface sobel_window_gen_if #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned HEIGHT      = 5,
    parameter int unsigned FIXED_WIDTH = 16
);
    logic                          start;
    logic                          busy;
    logic                          done;
    logic [FIXED_WIDTH-1:0]        pix_in;
    logic                          in_valid;
    logic                          in_ready;
    logic [9*FIXED_WIDTH-1:0]      win_out;
    logic [$clog2(HEIGHT)-1:0]     win_row;
    logic [$clog2(WIDTH)-1:0]      win_col;
    logic                          win_last;
    logic                          win_valid;
    logic                          win_ready;

    modport slave (
        input  start, pix_in, in_valid, win_ready,
        output busy, done, in_ready, win_out, win_row, win_col, win_last, win_valid
    );

    modport master (
        output start, pix_in, in_valid, win_ready,
        input  busy, done, in_ready, win_out, win_row, win_col, win_last, win_valid
    );
endinterface

// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming zero-padded 3x3 window generator.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  sobel_window_gen_if.slave (frame control, pixel input, window output)
// Scans (HEIGHT+1)x(WIDTH+1) positions; the extra column/row are virtual and
// inject zeros so the right and bottom borders are produced without input.
module sobel_window_gen #(
    parameter int unsigned WIDTH       = 5,
    parameter int unsigned HEIGHT      = 5,
    parameter int unsigned FIXED_WIDTH = 16
) (
    input logic               clk,
    input logic               rst,
    sobel_window_gen_if.slave bus
);
    localparam int unsigned FW   = FIXED_WIDTH;
    localparam int unsigned SrW  = $clog2(HEIGHT + 1);
    localparam int unsigned ScW  = $clog2(WIDTH + 1);
    localparam int unsigned RowW = $clog2(HEIGHT);
    localparam int unsigned ColW = $clog2(WIDTH);
    localparam logic [SrW-1:0] LastSr = SrW'(HEIGHT);
    localparam logic [ScW-1:0] LastSc = ScW'(WIDTH);

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;
    // One window column: [0] = top row, [2] = bottom row.
    typedef logic [2:0][FW-1:0] col_t;

    state_e          state_q, state_d;
    logic [SrW-1:0]  sr_q, sr_d;
    logic [ScW-1:0]  sc_q, sc_d;
    logic [FW-1:0]   lb0_q [WIDTH];  // row sr-1
    logic [FW-1:0]   lb1_q [WIDTH];  // row sr-2
    col_t            c1_q, c1_d, c2_q, c2_d, cur_col;
    logic [9*FW-1:0] win_out_q, win_out_d, win_next;
    logic [RowW-1:0] win_row_q, win_row_d;
    logic [ColW-1:0] win_col_q, win_col_d;
    logic            win_last_q, win_last_d;
    logic            win_valid_q, win_valid_d;
    logic            done_q, done_d;

    logic            col_in, real_pos, emit, out_free, fire, load, last_step;
    logic [ColW-1:0] lb_idx;
    logic [SrW-1:0]  sr_m1;
    logic [ScW-1:0]  sc_m1;

    // Datapath: current column and assembled window.
    always_comb begin
        lb_idx    = sc_q[ColW-1:0];
        col_in    = (sc_q != LastSc);
        real_pos  = col_in && (sr_q != LastSr);
        emit      = (sr_q != '0) && (sc_q != '0);
        last_step = (sr_q == LastSr) && (sc_q == LastSc);
        // Row masks stand in for the top padding, so stale line-buffer data
        // from an earlier or aborted frame is never visible.
        cur_col = '0;
        if (col_in && (sr_q >= SrW'(2))) cur_col[0] = lb1_q[lb_idx];
        if (col_in && (sr_q != '0))      cur_col[1] = lb0_q[lb_idx];
        if (real_pos)                    cur_col[2] = bus.pix_in;
        win_next = '0;
        for (int m = 0; m < 3; m++) begin
            win_next[(3*m + 0)*FW +: FW] = c2_q[m];
            win_next[(3*m + 1)*FW +: FW] = c1_q[m];
            win_next[(3*m + 2)*FW +: FW] = cur_col[m];
        end
    end

    // Control FSM and output register next-state.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        sc_d        = sc_q;
        c1_d        = c1_q;
        c2_d        = c2_q;
        done_d      = 1'b0;
        fire        = 1'b0;
        out_free    = !emit || !win_valid_q || bus.win_ready;
        win_out_d   = win_out_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_last_d  = win_last_q;
        win_valid_d = win_valid_q;
        sr_m1       = sr_q - 1'b1;
        sc_m1       = sc_q - 1'b1;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StScan;
                    sr_d    = '0;
                    sc_d    = '0;
                end
            end
            StScan: begin
                fire = (!real_pos || bus.in_valid) && out_free;
                if (fire) begin
                    // Column 0 starts a row: the column left of it is padding.
                    c2_d = (sc_q == '0) ? '0 : c1_q;
                    c1_d = cur_col;
                    if (last_step) begin
                        state_d = StDrain;
                    end else if (sc_q == LastSc) begin
                        sc_d = '0;
                        sr_d = sr_q + 1'b1;
                    end else begin
                        sc_d = sc_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (win_valid_q && bus.win_ready) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        load = fire && emit;
        if (load) begin
            win_out_d   = win_next;
            win_row_d   = sr_m1[RowW-1:0];
            win_col_d   = sc_m1[ColW-1:0];
            win_last_d  = last_step;
            win_valid_d = 1'b1;
        end else if (win_valid_q && bus.win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            sc_q        <= '0;
            c1_q        <= '0;
            c2_q        <= '0;
            win_out_q   <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_last_q  <= 1'b0;
            win_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            sc_q        <= sc_d;
            c1_q        <= c1_d;
            c2_q        <= c2_d;
            win_out_q   <= win_out_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_last_q  <= win_last_d;
            win_valid_q <= win_valid_d;
            done_q      <= done_d;
        end
    end

    // Line buffers: the previous row shifts down as the new pixel lands.
    always_ff @(posedge clk) begin
        if (fire && real_pos) begin
            lb1_q[lb_idx] <= lb0_q[lb_idx];
            lb0_q[lb_idx] <= bus.pix_in;
        end
    end

    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = done_q;
    assign bus.in_ready  = (state_q == StScan) && real_pos && out_free;
    assign bus.win_out   = win_out_q;
    assign bus.win_row   = win_row_q;
    assign bus.win_col   = win_col_q;
    assign bus.win_last  = win_last_q;
    assign bus.win_valid = win_valid_q;
endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: scoreboard bench for sobel_window_gen (5x5 frames).
// Stimulus pushes expected windows into a queue; the monitor pops and compares
// on every window handshake.
module tb_sobel_window_gen;
    localparam int W  = 5;
    localparam int H  = 5;
    localparam int FW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sobel_window_gen_if #(.WIDTH(W), .HEIGHT(H), .FIXED_WIDTH(FW)) bus ();

    sobel_window_gen #(.WIDTH(W), .HEIGHT(H), .FIXED_WIDTH(FW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [9*FW-1:0] w;
        int              row;
        int              col;
        bit              last;
    } exp_t;

    exp_t sb[$];
    int   checks     = 0;
    int   errors     = 0;
    int   fed_idx    = 0;
    int   frame_wins = 0;
    bit   ignore     = 1'b1;
    bit   ready_mode = 1'b0;

    int unsigned h00 [9] = '{0, 0, 0, 0, 256, 512, 0, 1536, 1792};
    int unsigned h22 [9] = '{1792, 2048, 2304, 3072, 3328, 3584, 4352, 4608, 4864};
    int unsigned h44 [9] = '{4864, 5120, 0, 6144, 6400, 0, 0, 0, 0};
    int unsigned hff [9] = '{0, 0, 0, 0, 65535, 65535, 0, 65535, 65535};

    task automatic chk(input string name, input logic [9*FW-1:0] act,
                       input logic [9*FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] pix(input int kind, input int r, input int c);
        if (kind == 1) return 16'hFFFF;
        return FW'((W*r + c + 1) << 8);
    endfunction

    function automatic logic [9*FW-1:0] model(input int kind, input int r, input int c);
        logic [9*FW-1:0] w;
        w = '0;
        for (int m = 0; m < 3; m++) begin
            for (int n = 0; n < 3; n++) begin
                int rr, cc;
                rr = r + m - 1;
                cc = c + n - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W)
                    w[(3*m + n)*FW +: FW] = pix(kind, rr, cc);
            end
        end
        return w;
    endfunction

    function automatic logic [9*FW-1:0] pack9(input int unsigned a [9]);
        logic [9*FW-1:0] w;
        for (int k = 0; k < 9; k++) w[k*FW +: FW] = FW'(a[k]);
        return w;
    endfunction

    task automatic push_frame(input int kind);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                exp_t e;
                e.w = model(kind, r, c);
                if (kind == 0 && r == 0 && c == 0) e.w = pack9(h00);
                if (kind == 0 && r == 2 && c == 2) e.w = pack9(h22);
                if (kind == 0 && r == 4 && c == 4) e.w = pack9(h44);
                if (kind == 1 && r == 0 && c == 0) e.w = pack9(hff);
                e.row  = r;
                e.col  = c;
                e.last = (r == H-1) && (c == W-1);
                sb.push_back(e);
            end
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_win_valid", bus.win_valid, 0);
        chk("rst_win_last", bus.win_last, 0);
        chk("rst_win_out", bus.win_out, 0);
        chk("rst_win_row", bus.win_row, 0);
        chk("rst_win_col", bus.win_col, 0);
    endtask

    // Downstream ready driver.
    initial begin
        bus.win_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.win_ready = ready_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor: scoreboard pops, stall stability, blocked-emit in_ready.
    initial begin : mon
        logic [9*FW-1:0] p_out;
        int              p_row, p_col;
        bit              p_stall;
        p_stall = 1'b0;
        p_out   = '0;
        p_row   = 0;
        p_col   = 0;
        forever begin
            @(negedge clk);
            if (ignore) begin
                p_stall = 1'b0;
                continue;
            end
            if (p_stall) begin
                chk("stall_valid", bus.win_valid, 1);
                chk("stall_out", bus.win_out, p_out);
                chk("stall_row", bus.win_row, p_row);
                chk("stall_col", bus.win_col, p_col);
            end
            // Mid-row input position always emits, so a stall must block input.
            if (bus.win_valid && !bus.win_ready && (fed_idx % W) != 0)
                chk("in_ready_blocked", bus.in_ready, 0);
            if (bus.win_valid && bus.win_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_window: got row %0d col %0d expected none",
                             bus.win_row, bus.win_col);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("win_out", bus.win_out, e.w);
                    chk("win_row", bus.win_row, e.row);
                    chk("win_col", bus.win_col, e.col);
                    chk("win_last", bus.win_last, e.last);
                end
                frame_wins++;
            end
            p_stall = bus.win_valid && !bus.win_ready;
            p_out   = bus.win_out;
            p_row   = int'(bus.win_row);
            p_col   = int'(bus.win_col);
        end
    end

    task automatic run_frame(input int kind, input bit gaps, input bit stalls,
                             input bit mid_start, input int exp_cyc);
        push_frame(kind);
        ready_mode = stalls;
        frame_wins = 0;
        fed_idx    = 0;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        fork
            begin : feed
                int guard;
                bit acc;
                guard = 0;
                while (fed_idx < W*H && guard < 3000) begin
                    bus.in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
                    bus.pix_in   = pix(kind, fed_idx / W, fed_idx % W);
                    @(negedge clk);
                    acc = bus.in_valid && bus.in_ready;
                    @(posedge clk);
                    #1;
                    if (acc) fed_idx++;
                    guard++;
                end
                bus.in_valid = 1'b0;
                chk("pixels_fed", fed_idx, W*H);
            end
            begin : wdone
                int cyc;
                bit got;
                cyc = 0;
                got = 1'b0;
                while (cyc < 3000 && !got) begin
                    @(negedge clk);
                    if (bus.done) got = 1'b1;
                    else cyc++;
                end
                chk("done_seen", got, 1);
                if (got) chk("busy_at_done", bus.busy, 0);
                if (exp_cyc != 0) chk("done_latency", cyc, exp_cyc);
            end
            begin : mids
                if (mid_start) begin
                    repeat (10) @(posedge clk);
                    #1 bus.start = 1'b1;
                    @(posedge clk);
                    #1 bus.start = 1'b0;
                end
            end
        join
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("win_count", frame_wins, W*H);
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.pix_in   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;
        ignore = 1'b0;

        // Input offered while idle must be refused.
        bus.in_valid = 1'b1;
        bus.pix_in   = 16'h1234;
        repeat (4) begin
            @(negedge clk);
            chk("idle_in_ready", bus.in_ready, 0);
            chk("idle_busy", bus.busy, 0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;

        run_frame(0, 1'b0, 1'b0, 1'b0, 37);
        run_frame(1, 1'b0, 1'b0, 1'b0, 37);
        run_frame(0, 1'b0, 1'b1, 1'b0, 0);
        run_frame(0, 1'b1, 1'b0, 1'b0, 0);
        run_frame(0, 1'b1, 1'b1, 1'b0, 0);

        // Abort a frame partway through.
        ignore     = 1'b1;
        ready_mode = 1'b0;
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bus.pix_in = pix(0, i / W, i % W);
            @(posedge clk);
            #1;
        end
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 rst = 1'b0;
        ignore = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("no_done_after_abort", bus.done, 0);
        end
        run_frame(0, 1'b0, 1'b0, 1'b0, 37);

        // Start pulse during SCAN must not disturb the frame.
        run_frame(0, 1'b0, 1'b0, 1'b1, 37);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sobel_window_gen.md
# sobel_window_gen

Streaming 3x3 window generator that sits directly upstream of the Sobel filter stage. It accepts one frame of Q8.8 pixels in raster order over a valid/ready handshake. It applies the one-pixel zero border that the filter expects and emits one zero-padded 3x3 neighbourhood per output pixel. Two internal line buffers hold the previous rows, so the filter stage never needs the whole padded frame resident.

## Interface
- `WIDTH`, 5: image columns, ≥2.
- `HEIGHT`, 5: image rows, ≥2.
- `FIXED_WIDTH`, 16: pixel width, Q8.8 unsigned.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  one-cycle pulse that begins a frame. Ignored unless the block is idle.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when the frame completes.
- `pix_in`  in  FIXED_WIDTH  input pixel.
- `in_valid`  in  1  `pix_in` is valid.
- `in_ready`  out  1  block accepts `pix_in` this cycle.
- `win_out`  out  9*FIXED_WIDTH  window. Element k=3m+n sits at bits [k*FIXED_WIDTH +: FIXED_WIDTH], where m is the row offset (0 = top) and n is the column offset (0 = left).
- `win_row`  out  $clog2(HEIGHT)  centre row r.
- `win_col`  out  $clog2(WIDTH)  centre column c.
- `win_last`  out  1  marks the window centred at (HEIGHT-1, WIDTH-1).
- `win_valid`  out  1  window registers are valid.
- `win_ready`  in  1  downstream accepts the window.

## Operation
- Element (m,n) of the window centred at (r,c) is pixel(r+m-1, c+n-1) when that coordinate lies inside the image, and 0 otherwise.
- States and transitions:
  - IDLE: `start` → SCAN. Clear scan counters. The top-padding rows are treated as zero; line-buffer contents from the previous frame must never leak into the new frame.
  - SCAN: walk scan positions (sr, sc) in raster order over 0..HEIGHT × 0..WIDTH, one position per step.
    - A position is *real* when sr<HEIGHT and sc<WIDTH. Real positions consume one input pixel. Virtual positions (sr=HEIGHT or sc=WIDTH) insert 0 internally and consume no input.
    - A position *emits* when sr≥1 and sc≥1. It emits the window centred at (sr-1, sc-1).
    - Step fire condition: (not real, or `in_valid`) AND (not emitting, or `win_valid`=0, or `win_ready`=1).
    - Leave SCAN → DRAIN on the step at (HEIGHT, WIDTH).
  - DRAIN: wait until the last window is accepted. Then pulse `done`, drop `busy`, and return to IDLE.
- `in_ready` = (state==SCAN) & real & (not emitting, or `win_valid`=0, or `win_ready`=1). This is combinational from `win_ready` and may be used by upstream in the same cycle.
- Output register is a single entry:
  - A firing emit step loads `win_out`, `win_row`, `win_col`, and `win_last`, and sets `win_valid`.
  - A handshake with no new load clears `win_valid`.
  - While `win_valid`=1 and `win_ready`=0, all window outputs hold stable.
- Line buffers: two rows of WIDTH entries, written at real positions only. No arithmetic is performed; pixel values pass through bit-exact.
- `start` while busy: ignored. `in_valid` outside SCAN: ignored, `in_ready`=0.
- `rst` mid-frame: abort the frame. No `done` pulse is generated. The next `start` begins a clean frame.

## Timing
- Reset values: `busy`=0, `done`=0, `in_ready`=0, `win_valid`=0, `win_last`=0, `win_out`=0, `win_row`=0, `win_col`=0, state=IDLE.
- The step at scan (r+1, c+1) fires in cycle t. The window centred at (r,c) has `win_valid`=1 at t+1.
- With continuous `in_valid` and `win_ready`, the block makes one step per cycle. SCAN lasts (HEIGHT+1)(WIDTH+1) cycles: 36 for 5x5.
- `done` is asserted the cycle after the `win_last` handshake. `busy` is 0 in that same cycle.
- Throughput is one pixel per cycle sustained, with no bubbles except at virtual positions.

## Test plan
- Frame 5x5, pixel(r,c)=(5r+c+1)<<8, no stalls:
  - Window (0,0) = [0,0,0, 0,256,512, 0,1536,1792].
  - Window (2,2) = [1792,2048,2304, 3072,3328,3584, 4352,4608,4864].
  - Window (4,4) = [4864,5120,0, 6144,6400,0, 0,0,0], with `win_last`=1.
  - Exactly 25 windows are emitted, and `done` occurs 37 cycles after `start`.
- Random `win_ready` stalls, same frame: identical window sequence with `win_out` stable during every stall. `in_ready` is low whenever an emit step is blocked.
- Random `in_valid` gaps: identical window sequence. Virtual positions (the column-5 and row-5 steps) advance without input.
- Back-to-back frames, where frame 2 is all 0xFFFF: frame-2 window (0,0) = [0,0,0, 0,0xFFFF,0xFFFF, 0,0xFFFF,0xFFFF]. No frame-1 data appears.
- `rst` asserted at step 12, then `start`: all outputs return to reset values on the next cycle, no `done` pulse appears, and the new frame produces the correct 25 windows.
- `start` pulsed during SCAN, and `in_valid` asserted in IDLE: both are ignored, and the `in_ready` and state sequences are unchanged.
